spm_ctrl_hs: RTL

Parametrised multi-cycle control unit for the stored-program RISC machine. It sequences fetch, decode and execute for the 9-opcode ISA plus HALT, over a configurable register file size and word width. Every memory access uses a req/ready handshake, so wait-state memories are supported. It drives the existing datapath: register loads, PC, IR, address register, Y/Z registers and both bus muxes.

---
 rtl/spm_ctrl_hs.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spm_ctrl_hs.sv
// spm_ctrl_hs: multi-cycle fetch/decode/execute sequencer for the
// stored-program RISC datapath. Memory accesses use a req/ready handshake,
// so any number of wait states is tolerated.
// Optional build macro SPM_CTRL_TIMEOUT_EN adds a watchdog that halts the
// machine with err set after TIMEOUT consecutive unanswered request cycles.
module spm_ctrl_hs #(
    parameter int WORD_SZ  = 8,
    parameter int OP_SZ    = 4,
    parameter int NUM_REGS = 4,
    parameter int REG_SEL  = 2,
    parameter int SEL1_SZ  = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_SZ-1:0]  instr,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [NUM_REGS-1:0] load_reg,
    output logic                load_pc,
    output logic                inc_pc,
    output logic                load_ir,
    output logic                load_add_r,
    output logic                load_reg_y,
    output logic                load_reg_z,
    output logic [SEL1_SZ-1:0]  bus1_sel,
    output logic [1:0]          bus2_sel,
    output logic                mem_req,
    output logic                write,
    output logic                halted,
    output logic                err
);

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
        S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
    } state_t;

    localparam logic [OP_SZ-1:0] OP_NOP  = OP_SZ'(0);
    localparam logic [OP_SZ-1:0] OP_ADD  = OP_SZ'(1);
    localparam logic [OP_SZ-1:0] OP_SUB  = OP_SZ'(2);
    localparam logic [OP_SZ-1:0] OP_AND  = OP_SZ'(3);
    localparam logic [OP_SZ-1:0] OP_NOT  = OP_SZ'(4);
    localparam logic [OP_SZ-1:0] OP_RD   = OP_SZ'(5);
    localparam logic [OP_SZ-1:0] OP_WR   = OP_SZ'(6);
    localparam logic [OP_SZ-1:0] OP_BR   = OP_SZ'(7);
    localparam logic [OP_SZ-1:0] OP_BRZ  = OP_SZ'(8);
    localparam logic [OP_SZ-1:0] OP_HALT = OP_SZ'(15);

    localparam logic [SEL1_SZ-1:0] SEL_PC = SEL1_SZ'(NUM_REGS);
    localparam logic [1:0] B2_ALU  = 2'd0;
    localparam logic [1:0] B2_BUS1 = 2'd1;
    localparam logic [1:0] B2_MEM  = 2'd2;

    state_t state_q, state_d;
    logic   err_q, err_set;
    logic   mem_state;
    logic   tmo_hit;

    logic [OP_SZ-1:0]   op;
    logic [REG_SEL-1:0] src, dst;
    logic               src_bad, dst_bad;

    assign op  = instr[WORD_SZ-1 -: OP_SZ];
    assign src = instr[2*REG_SEL-1:REG_SEL];
    assign dst = instr[REG_SEL-1:0];

    // Register fields can name registers that do not exist when NUM_REGS < 2**REG_SEL
    assign src_bad = (int'(src) >= NUM_REGS);
    assign dst_bad = (int'(dst) >= NUM_REGS);

    assign mem_state = (state_q inside {S_FET2, S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2});
    assign err       = err_q;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_SEL-1:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            r[i] = (int'(idx) == i);
        end
        return r;
    endfunction

`ifdef SPM_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = mem_state && (tmo_q == TMO_W'(TIMEOUT));

    // Watchdog: consecutive unanswered request cycles, cleared on any state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (state_d != state_q) begin
            tmo_q <= '0;
        end else if (mem_state && !mem_ready && !tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    // No watchdog in this build; TIMEOUT stays referenced so both builds share one parameter list
    assign tmo_hit = 1'b0 && (TIMEOUT > 0);
`endif

    // State register and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d    = state_q;
        err_set    = 1'b0;
        load_reg   = '0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        bus1_sel   = '0;
        bus2_sel   = B2_ALU;
        mem_req    = mem_state;
        write      = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: begin
                bus1_sel   = SEL_PC;
                bus2_sel   = B2_BUS1;
                load_add_r = 1'b1;
                state_d    = S_FET2;
            end
            S_FET2: begin
                bus2_sel = B2_MEM;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                case (op)
                    OP_NOP: state_d = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        if (src_bad) begin
                            err_set = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            bus1_sel   = SEL1_SZ'(src);
                            bus2_sel   = B2_BUS1;
                            load_reg_y = 1'b1;
                            state_d    = S_EX1;
                        end
                    end
                    OP_NOT: begin
                        if (src_bad || dst_bad) begin
                            err_set = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            bus1_sel   = SEL1_SZ'(src);
                            bus2_sel   = B2_ALU;
                            load_reg   = reg_onehot(dst);
                            load_reg_z = 1'b1;
                            state_d    = S_FET1;
                        end
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                        if (op == OP_BRZ && !zero) begin
                            // Branch not taken: step over the target address word
                            inc_pc  = 1'b1;
                            state_d = S_FET1;
                        end else begin
                            bus1_sel   = SEL_PC;
                            bus2_sel   = B2_BUS1;
                            load_add_r = 1'b1;
                            state_d    = (op == OP_RD) ? S_RD1 :
                                         (op == OP_WR) ? S_WR1 : S_BR1;
                        end
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        err_set = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_EX1: begin
                if (dst_bad) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    bus1_sel   = SEL1_SZ'(dst);
                    bus2_sel   = B2_ALU;
                    load_reg   = reg_onehot(dst);
                    load_reg_z = 1'b1;
                    state_d    = S_FET1;
                end
            end
            S_RD1, S_WR1: begin
                bus2_sel = B2_MEM;
                if (mem_ready) begin
                    load_add_r = 1'b1;
                    inc_pc     = 1'b1;
                    state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
                end
            end
            S_RD2: begin
                bus2_sel = B2_MEM;
                if (mem_ready) begin
                    load_reg = reg_onehot(dst);
                    state_d  = S_FET1;
                end
            end
            S_WR2: begin
                bus1_sel = SEL1_SZ'(src);
                if (mem_ready) begin
                    write   = 1'b1;
                    state_d = S_FET1;
                end
            end
            S_BR1: begin
                bus2_sel = B2_MEM;
                if (mem_ready) begin
                    load_add_r = 1'b1;
                    state_d    = S_BR2;
                end
            end
            S_BR2: begin
                bus2_sel = B2_MEM;
                if (mem_ready) begin
                    load_pc = 1'b1;
                    state_d = S_FET1;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Watchdog expiry overrides whatever the access would have done this cycle
        if (tmo_hit) begin
            load_reg   = '0;
            load_pc    = 1'b0;
            inc_pc     = 1'b0;
            load_ir    = 1'b0;
            load_add_r = 1'b0;
            load_reg_y = 1'b0;
            load_reg_z = 1'b0;
            write      = 1'b0;
            err_set    = 1'b1;
            state_d    = S_HALT;
        end
    end

endmodule
